// File: rtl/heap_pop_writeback_buffer_pkg.sv
// Shared heap definitions used by decode, the heap unit and the pop writeback buffer.
// Holds the default widths and depth, plus the push/pop encoding carried in rd.
package heap_pop_writeback_buffer_pkg;

   localparam int HEAP_DATA_W = 32;
   localparam int HEAP_TAG_W  = 5;
   localparam int HEAP_DEPTH  = 4;

   typedef enum logic {
      HEAP_RD_PUSH = 1'b0,
      HEAP_RD_POP  = 1'b1
   } heap_rd_e;

endpackage

// File: rtl/heap_pop_writeback_buffer.sv
// Pairs issued heap pops with returned heap values and presents the results in issue
// order to the writeback port. It also throttles issue when full and records protocol errors.
module heap_pop_writeback_buffer
   import heap_pop_writeback_buffer_pkg::*;
#(
   parameter int DEPTH  = HEAP_DEPTH,
   parameter int DATA_W = HEAP_DATA_W,
   parameter int TAG_W  = HEAP_TAG_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pop_issue,
   input  logic [TAG_W-1:0]           pop_rd,
   output logic                       issue_stall,
   input  logic                       heap_v,
   input  logic [DATA_W-1:0]          heap_data,
   output logic                       wb_valid,
   input  logic                       wb_ready,
   output logic [TAG_W-1:0]           wb_rd,
   output logic [DATA_W-1:0]          wb_data,
   output logic [$clog2(DEPTH+1)-1:0] pending_cnt,
   output logic                       err_overflow,
   output logic                       err_orphan
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [TAG_W-1:0]  tag_mem  [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [DEPTH-1:0]  filled;

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  fill_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  unfilled;

   logic do_issue;
   logic do_fill;
   logic do_retire;

   // Stall comes from registered occupancy only, so a same-cycle retire cannot free a slot.
   assign issue_stall = (count == CNT_W'(DEPTH));
   assign do_issue    = pop_issue && !issue_stall;
   assign do_fill     = heap_v && (unfilled != '0);
   assign do_retire   = wb_valid && wb_ready;

   assign wb_valid    = (count != '0) && filled[rd_ptr];
   assign wb_rd       = wb_valid ? tag_mem[rd_ptr]  : '0;
   assign wb_data     = wb_valid ? data_mem[rd_ptr] : '0;
   assign pending_cnt = count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr       <= '0;
         fill_ptr     <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         unfilled     <= '0;
         filled       <= '0;
         err_overflow <= 1'b0;
         err_orphan   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_mem[i]  <= '0;
            data_mem[i] <= '0;
         end
      end else begin
         // Issue, fill and retire always address distinct entries, so their updates never collide.
         if (do_issue) begin
            tag_mem[wr_ptr] <= pop_rd;
            filled[wr_ptr]  <= 1'b0;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         if (do_fill) begin
            data_mem[fill_ptr] <= heap_data;
            filled[fill_ptr]   <= 1'b1;
            fill_ptr           <= fill_ptr + PTR_W'(1);
         end
         if (do_retire) begin
            filled[rd_ptr] <= 1'b0;
            rd_ptr         <= rd_ptr + PTR_W'(1);
         end

         count    <= count + CNT_W'(do_issue) - CNT_W'(do_retire);
         unfilled <= unfilled + CNT_W'(do_issue) - CNT_W'(do_fill);

         if (pop_issue && issue_stall)
            err_overflow <= 1'b1;
         if (heap_v && (unfilled == '0))
            err_orphan <= 1'b1;
      end
   end

endmodule

// File: tb/tb_heap_pop_writeback_buffer.sv
// Directed bench for heap_pop_writeback_buffer: hand-computed expectations for reset,
// ordering, backpressure, simultaneous events, pointer wrap and error flags.
module tb_heap_pop_writeback_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        pop_issue;
   logic [4:0]  pop_rd;
   logic        issue_stall;
   logic        heap_v;
   logic [31:0] heap_data;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [2:0]  pending_cnt;
   logic        err_overflow;
   logic        err_orphan;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   heap_pop_writeback_buffer dut (
      .clk          (clk),
      .reset        (reset),
      .pop_issue    (pop_issue),
      .pop_rd       (pop_rd),
      .issue_stall  (issue_stall),
      .heap_v       (heap_v),
      .heap_data    (heap_data),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .pending_cnt  (pending_cnt),
      .err_overflow (err_overflow),
      .err_orphan   (err_orphan)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Inputs change 1ns after the edge; outputs are sampled at that point too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic head(input string tag, input logic [4:0] rd, input logic [31:0] data,
                       input logic [2:0] cnt);
      chk({tag, "_valid"}, wb_valid, 1'b1);
      chk({tag, "_rd"}, wb_rd, rd);
      chk({tag, "_data"}, wb_data, data);
      chk({tag, "_cnt"}, pending_cnt, cnt);
   endtask

   initial begin
      reset = 1'b0; pop_issue = 1'b0; pop_rd = '0; heap_v = 1'b0; heap_data = '0; wb_ready = 1'b0;
      #1;

      // Reset holds everything at 0 even with activity on the inputs.
      pop_issue = 1'b1; pop_rd = 5'd3; heap_v = 1'b1; heap_data = 32'h11; wb_ready = 1'b1;
      tick(); tick(); tick();
      chk("rst_valid", wb_valid, 1'b0);
      chk("rst_rd", wb_rd, 5'd0);
      chk("rst_data", wb_data, 32'd0);
      chk("rst_stall", issue_stall, 1'b0);
      chk("rst_cnt", pending_cnt, 3'd0);
      chk("rst_ovf", err_overflow, 1'b0);
      chk("rst_orph", err_orphan, 1'b0);
      reset = 1'b1; pop_issue = 1'b0; heap_v = 1'b0; wb_ready = 1'b0;
      tick();
      chk("rel_cnt", pending_cnt, 3'd0);
      heap_v = 1'b1; heap_data = 32'h22;
      tick();
      heap_v = 1'b0;
      chk("post_rst_orph", err_orphan, 1'b1);
      chk("post_rst_valid", wb_valid, 1'b0);
      do_reset();
      chk("rst2_orph", err_orphan, 1'b0);

      // Single pop: issue at edge 1, result at edge 3, retire at edge 4.
      pop_issue = 1'b1; pop_rd = 5'd7;
      tick();
      pop_issue = 1'b0;
      chk("single_cnt1", pending_cnt, 3'd1);
      chk("single_nv1", wb_valid, 1'b0);
      tick();
      chk("single_nv2", wb_valid, 1'b0);
      heap_v = 1'b1; heap_data = 32'h55; wb_ready = 1'b1;
      tick();
      heap_v = 1'b0;
      head("single", 5'd7, 32'h55, 3'd1);
      tick();
      chk("single_done_valid", wb_valid, 1'b0);
      chk("single_done_cnt", pending_cnt, 3'd0);
      chk("single_done_rd", wb_rd, 5'd0);
      wb_ready = 1'b0;

      // In-order pairing under backpressure.
      pop_issue = 1'b1; pop_rd = 5'd3;
      tick();
      pop_rd = 5'd4; heap_v = 1'b1; heap_data = 32'h30;
      tick();
      pop_rd = 5'd5; heap_data = 32'h40;
      tick();
      pop_issue = 1'b0; heap_data = 32'h50;
      tick();
      heap_v = 1'b0;
      head("ord_h0", 5'd3, 32'h30, 3'd3);
      tick();
      head("ord_hold", 5'd3, 32'h30, 3'd3);
      wb_ready = 1'b1;
      tick();
      head("ord_h1", 5'd4, 32'h40, 3'd2);
      tick();
      head("ord_h2", 5'd5, 32'h50, 3'd1);
      tick();
      chk("ord_empty", wb_valid, 1'b0);
      chk("ord_cnt", pending_cnt, 3'd0);
      wb_ready = 1'b0;

      // Fill to capacity, overflow, and retire-with-issue that must still be dropped.
      pop_issue = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         pop_rd = 5'(i);
         tick();
      end
      chk("full_stall", issue_stall, 1'b1);
      chk("full_cnt", pending_cnt, 3'd4);
      chk("full_ovf0", err_overflow, 1'b0);
      pop_rd = 5'd6;
      tick();
      pop_issue = 1'b0;
      chk("full_ovf1", err_overflow, 1'b1);
      chk("full_cnt5", pending_cnt, 3'd4);
      heap_v = 1'b1; heap_data = 32'hA1;
      tick();
      heap_v = 1'b0;
      head("full_h", 5'd1, 32'hA1, 3'd4);
      wb_ready = 1'b1; pop_issue = 1'b1; pop_rd = 5'd8;
      tick();
      wb_ready = 1'b0;
      chk("nobypass_cnt", pending_cnt, 3'd3);
      chk("nobypass_stall", issue_stall, 1'b0);
      tick();
      pop_issue = 1'b0;
      chk("reissue_cnt", pending_cnt, 3'd4);
      chk("reissue_stall", issue_stall, 1'b1);
      wb_ready = 1'b1; heap_v = 1'b1;
      heap_data = 32'hA2; tick();
      heap_data = 32'hA3; tick();
      heap_data = 32'hA4; tick();
      heap_data = 32'hA8; tick();
      heap_v = 1'b0;
      head("drain_h", 5'd8, 32'hA8, 3'd1);
      tick();
      wb_ready = 1'b0;
      chk("drain_cnt", pending_cnt, 3'd0);
      chk("drain_orph", err_orphan, 1'b0);

      // Simultaneous issue/fill/retire with wr_ptr wrapping 3 -> 0.
      do_reset();
      chk("sim_ovf_clr", err_overflow, 1'b0);
      pop_issue = 1'b1; pop_rd = 5'd1;
      tick();
      pop_rd = 5'd2; heap_v = 1'b1; heap_data = 32'hB1;
      tick();
      head("sim_a", 5'd1, 32'hB1, 3'd2);
      pop_issue = 1'b0; heap_data = 32'hB2; wb_ready = 1'b1;
      tick();
      heap_v = 1'b0;
      head("sim_b", 5'd2, 32'hB2, 3'd1);
      tick();
      wb_ready = 1'b0;
      chk("sim_empty", pending_cnt, 3'd0);
      pop_issue = 1'b1; pop_rd = 5'd3;
      tick();
      pop_rd = 5'd4; heap_v = 1'b1; heap_data = 32'hC3;
      tick();
      head("sim_c", 5'd3, 32'hC3, 3'd2);
      pop_rd = 5'd9; heap_data = 32'hC4; wb_ready = 1'b1;
      tick();
      head("sim_triple", 5'd4, 32'hC4, 3'd2);
      pop_rd = 5'd10; heap_data = 32'hC9;
      tick();
      head("sim_wrap", 5'd9, 32'hC9, 3'd2);
      pop_issue = 1'b0; heap_data = 32'hCA;
      tick();
      heap_v = 1'b0;
      head("sim_last", 5'd10, 32'hCA, 3'd1);
      tick();
      wb_ready = 1'b0;
      chk("sim_done_valid", wb_valid, 1'b0);
      chk("sim_done_cnt", pending_cnt, 3'd0);
      chk("sim_orph", err_orphan, 1'b0);

      // heap_v in the same cycle as issuing the only pop is an orphan.
      pop_issue = 1'b1; pop_rd = 5'd12; heap_v = 1'b1; heap_data = 32'h77;
      tick();
      pop_issue = 1'b0; heap_data = 32'h78;
      chk("same_orph", err_orphan, 1'b1);
      chk("same_cnt", pending_cnt, 3'd1);
      chk("same_nv", wb_valid, 1'b0);
      tick();
      heap_v = 1'b0;
      head("same_h", 5'd12, 32'h78, 3'd1);

      // Plain orphan with nothing pending.
      do_reset();
      heap_v = 1'b1; heap_data = 32'hAA;
      tick();
      heap_v = 1'b0;
      chk("orph_flag", err_orphan, 1'b1);
      chk("orph_valid", wb_valid, 1'b0);
      chk("orph_data", wb_data, 32'd0);
      chk("orph_cnt", pending_cnt, 3'd0);
      tick();
      chk("orph_sticky", err_orphan, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
